// File: rtl/y86_mem_arbiter.sv
// Shares one asynchronous-read memory between the y86 core (absolute priority) and a
// loader/debug port; also holds the core in reset while it is being boot-loaded.
module y86_mem_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] core_A,
    input  logic [DW-1:0] core_wdata,
    input  logic          core_we,
    input  logic          core_re_n,
    output logic [DW-1:0] core_rdata,
    output logic          core_rst,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    input  logic          boot_go,
    input  logic          core_stop,
    output logic          dbg_timeout,
    input  logic          timeout_clr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic            rvalid_q, rvalid_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            timeout_q, timeout_d;
    logic            core_busy;
    logic            core_own;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_BOOT;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    // Grant, bus mux, state sequencing and starvation tracking.
    always_comb begin
        state_d   = state_q;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        wait_d    = '0;
        timeout_d = timeout_q;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;

        core_busy = core_we | ~core_re_n;
        core_own  = rst & (state_q == ST_RUN) & core_busy;
        dbg_gnt   = rst & dbg_req & ((state_q == ST_BOOT) | ~core_busy);

        unique case (state_q)
            ST_BOOT: if (boot_go)   state_d = ST_RUN;
            ST_RUN:  if (core_stop) state_d = ST_BOOT;
            default: state_d = ST_BOOT;
        endcase

        if (core_own) begin
            mem_addr  = core_A;
            mem_wdata = core_wdata;
            mem_we    = core_we;
            mem_re    = ~core_re_n;
        end else if (dbg_gnt) begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_we    = dbg_we;
            mem_re    = ~dbg_we;
        end

        if (dbg_gnt && !dbg_we) begin
            rvalid_d = 1'b1;
            rdata_d  = mem_rdata;
        end

        // Count consecutive denied cycles while the core runs; set beats clear.
        if ((state_q == ST_RUN) && dbg_req && !dbg_gnt) begin
            wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WW'(1);
        end
        if (wait_d == WAIT_MAX) begin
            timeout_d = 1'b1;
        end else if (timeout_clr) begin
            timeout_d = 1'b0;
        end
    end

    assign core_rdata  = mem_rdata;
    assign core_rst    = ~rst | (state_q == ST_BOOT);
    assign dbg_rvalid  = rvalid_q;
    assign dbg_rdata   = rdata_q;
    assign dbg_timeout = timeout_q;

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Bench for y86_mem_arbiter: memory model plus a queue of expected debug read data.
module tb_y86_mem_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] core_A;
    logic [31:0] core_wdata;
    logic        core_we;
    logic        core_re_n;
    logic [31:0] core_rdata;
    logic        core_rst;
    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        boot_go;
    logic        core_stop;
    logic        dbg_timeout;
    logic        timeout_clr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;

    logic [31:0] mem     [0:255];
    logic [31:0] exp_mem [0:255];
    logic [31:0] exp_q   [$];
    int          n_tests;
    int          n_fail;

    y86_mem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(3)) dut (
        .clk(clk), .rst(rst),
        .core_A(core_A), .core_wdata(core_wdata), .core_we(core_we), .core_re_n(core_re_n),
        .core_rdata(core_rdata), .core_rst(core_rst),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .boot_go(boot_go), .core_stop(core_stop),
        .dbg_timeout(dbg_timeout), .timeout_clr(timeout_clr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous-read memory, synchronous write.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr[7:0]];

    task automatic idle_inputs();
        core_A = '0; core_wdata = '0; core_we = 1'b0; core_re_n = 1'b1;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        boot_go = 1'b0; core_stop = 1'b0; timeout_clr = 1'b0;
    endtask

    // Advance to the next negedge and retire any debug read due in this cycle.
    task automatic advance();
        logic [31:0] e;
        @(negedge clk);
        if (dbg_rvalid === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL rvalid_spurious: rvalid=1 rdata=%h, none expected", dbg_rdata);
            end else begin
                e = exp_q.pop_front();
                if (dbg_rdata !== e) begin
                    n_fail++; $display("FAIL rdata: got %h want %h", dbg_rdata, e);
                end
            end
        end else if (exp_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL rvalid_missing: rvalid=%b want 1 (%0d pending)", dbg_rvalid, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b1; core_we = 1'b1;
        advance(); advance();
        #1;
        n_tests++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL reset_core_rst: got %b want 1", core_rst); end
        n_tests++; if (dbg_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0", dbg_gnt); end
        n_tests++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got we=%b re=%b want 0 0", mem_we, mem_re); end
        n_tests++; if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rd: got rvalid=%b rdata=%h want 0 0", dbg_rvalid, dbg_rdata); end
        n_tests++; if (dbg_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", dbg_timeout); end
        advance();
        idle_inputs();
        rst = 1'b1;
    endtask

    task automatic test_boot_load();
        logic [31:0] addrs [5];
        logic [31:0] datas [5];
        addrs = '{32'h0, 32'h1, 32'h4, 32'h5, 32'h40};
        datas = '{32'h0000_0001, 32'h0000_00F4, 32'h1111_2222, 32'h3333_4444, 32'hCAFE_0040};
        for (int i = 0; i < 5; i++) begin
            advance();
            dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = addrs[i]; dbg_wdata = datas[i];
            core_re_n = 1'b0;  // core bus must be ignored in BOOT
            #1;
            n_tests++;
            if (dbg_gnt !== 1'b1 || mem_we !== 1'b1 || core_rst !== 1'b1 || mem_addr !== addrs[i] || mem_wdata !== datas[i]) begin
                n_fail++;
                $display("FAIL boot_write[%0d]: got gnt=%b we=%b core_rst=%b addr=%h wdata=%h want 1 1 1 %h %h",
                         i, dbg_gnt, mem_we, core_rst, mem_addr, mem_wdata, addrs[i], datas[i]);
            end
            exp_mem[addrs[i][7:0]] = datas[i];
        end
        advance();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h1; core_re_n = 1'b1;
        #1;
        n_tests++; if (dbg_gnt !== 1'b1 || mem_re !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL boot_read: got gnt=%b re=%b we=%b want 1 1 0", dbg_gnt, mem_re, mem_we); end
        exp_q.push_back(exp_mem[1]);
        advance();
        idle_inputs();
        #1;
        n_tests++; if (mem_addr !== 32'h0 || mem_re !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL idle_bus: got addr=%h re=%b we=%b want 0 0 0", mem_addr, mem_re, mem_we); end
    endtask

    task automatic test_boot_go();
        advance();
        boot_go = 1'b1; core_stop = 1'b1;
        #1;
        n_tests++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL go_same_cycle: got core_rst=%b want 1", core_rst); end
        advance();
        boot_go = 1'b0; core_stop = 1'b0;
        core_re_n = 1'b0; core_A = 32'h0;
        #1;
        n_tests++; if (core_rst !== 1'b0) begin n_fail++; $display("FAIL go_core_rst: got %b want 0", core_rst); end
        n_tests++;
        if (mem_addr !== 32'h0 || mem_re !== 1'b1 || core_rdata !== exp_mem[0]) begin
            n_fail++; $display("FAIL first_fetch: got addr=%h re=%b rdata=%h want 0 1 %h", mem_addr, mem_re, core_rdata, exp_mem[0]);
        end
    endtask

    task automatic test_contention();
        advance();
        core_re_n = 1'b0; core_A = 32'h4;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40;
        #1;
        n_tests++;
        if (dbg_gnt !== 1'b0 || mem_addr !== 32'h4 || core_rdata !== exp_mem[4]) begin
            n_fail++; $display("FAIL contend_core: got gnt=%b addr=%h rdata=%h want 0 4 %h", dbg_gnt, mem_addr, core_rdata, exp_mem[4]);
        end
        advance();
        core_re_n = 1'b1;
        #1;
        n_tests++;
        if (dbg_gnt !== 1'b1 || mem_addr !== 32'h40 || mem_re !== 1'b1) begin
            n_fail++; $display("FAIL contend_dbg: got gnt=%b addr=%h re=%b want 1 40 1", dbg_gnt, mem_addr, mem_re);
        end
        exp_q.push_back(exp_mem[8'h40]);
        advance();
        idle_inputs();
    endtask

    task automatic test_store_vs_dbg();
        advance();
        core_we = 1'b1; core_A = 32'h10; core_wdata = 32'hAAAA_5555;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'h1234_5678;
        #1;
        n_tests++;
        if (dbg_gnt !== 1'b0 || mem_addr !== 32'h10 || mem_wdata !== 32'hAAAA_5555 || mem_we !== 1'b1) begin
            n_fail++; $display("FAIL store_core: got gnt=%b addr=%h wdata=%h we=%b want 0 10 aaaa5555 1", dbg_gnt, mem_addr, mem_wdata, mem_we);
        end
        exp_mem[8'h10] = 32'hAAAA_5555;
        advance();
        core_we = 1'b0;
        #1;
        n_tests++;
        if (dbg_gnt !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'h1234_5678 || mem_we !== 1'b1) begin
            n_fail++; $display("FAIL store_dbg: got gnt=%b addr=%h wdata=%h we=%b want 1 20 12345678 1", dbg_gnt, mem_addr, mem_wdata, mem_we);
        end
        exp_mem[8'h20] = 32'h1234_5678;
        advance();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        addrs = '{32'h10, 32'h20, 32'h1};
        for (int i = 0; i < 3; i++) begin
            if (i != 0) advance();
            dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = addrs[i];
            #1;
            n_tests++; if (dbg_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt[%0d]: got %b want 1", i, dbg_gnt); end
            exp_q.push_back(exp_mem[addrs[i][7:0]]);
        end
        advance();
        idle_inputs();
        advance();
    endtask

    task automatic test_starvation();
        core_re_n = 1'b0; core_A = 32'h0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h5;
        for (int i = 1; i <= 3; i++) begin
            advance();
            n_tests++;
            if (dbg_timeout !== (i == 3)) begin
                n_fail++; $display("FAIL starve_cycle%0d: got timeout=%b want %b", i, dbg_timeout, (i == 3));
            end
        end
        core_re_n = 1'b1;
        #1;
        exp_q.push_back(exp_mem[5]);
        advance();
        dbg_req = 1'b0;
        n_tests++; if (dbg_timeout !== 1'b1) begin n_fail++; $display("FAIL starve_sticky: got %b want 1", dbg_timeout); end
        timeout_clr = 1'b1;
        advance();
        n_tests++; if (dbg_timeout !== 1'b0) begin n_fail++; $display("FAIL starve_clr: got %b want 0", dbg_timeout); end
        // Set and clear together on the third denied cycle: set must win.
        core_re_n = 1'b0; dbg_req = 1'b1;
        for (int i = 1; i <= 3; i++) advance();
        n_tests++; if (dbg_timeout !== 1'b1) begin n_fail++; $display("FAIL starve_set_wins: got %b want 1", dbg_timeout); end
        core_re_n = 1'b1;
        #1;
        exp_q.push_back(exp_mem[5]);
        advance();
        idle_inputs();
        timeout_clr = 1'b1;
        advance();
        timeout_clr = 1'b0;
    endtask

    task automatic test_stop();
        core_we = 1'b1; core_A = 32'h30; core_wdata = 32'hDEAD_BEEF;
        core_stop = 1'b1; boot_go = 1'b1;
        #1;
        n_tests++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h30 || core_rst !== 1'b0) begin
            n_fail++; $display("FAIL stop_write: got we=%b addr=%h core_rst=%b want 1 30 0", mem_we, mem_addr, core_rst);
        end
        exp_mem[8'h30] = 32'hDEAD_BEEF;
        advance();
        idle_inputs();
        core_stop = 1'b1;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h30;
        #1;
        n_tests++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL stop_core_rst: got %b want 1", core_rst); end
        n_tests++; if (dbg_gnt !== 1'b1) begin n_fail++; $display("FAIL stop_boot_gnt: got %b want 1", dbg_gnt); end
        exp_q.push_back(exp_mem[8'h30]);
        advance();
        idle_inputs();
        n_tests++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL stop_in_boot: got core_rst=%b want 1", core_rst); end
    endtask

    task automatic test_midreset();
        boot_go = 1'b1;
        advance();
        boot_go = 1'b0;
        core_re_n = 1'b0; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h5;
        for (int i = 0; i < 3; i++) advance();
        n_tests++; if (dbg_timeout !== 1'b1) begin n_fail++; $display("FAIL mid_pre_timeout: got %b want 1", dbg_timeout); end
        core_re_n = 1'b1;
        #1;
        exp_q.push_back(exp_mem[5]);
        advance();
        rst = 1'b0;
        #1;
        n_tests++;
        if (core_rst !== 1'b1 || dbg_gnt !== 1'b0 || mem_re !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_comb: got core_rst=%b gnt=%b re=%b want 1 0 0", core_rst, dbg_gnt, mem_re);
        end
        advance();
        n_tests++;
        if (dbg_rvalid !== 1'b0 || dbg_timeout !== 1'b0 || dbg_rdata !== 32'h0) begin
            n_fail++; $display("FAIL mid_rst_regs: got rvalid=%b timeout=%b rdata=%h want 0 0 0", dbg_rvalid, dbg_timeout, dbg_rdata);
        end
        rst = 1'b1;
        core_re_n = 1'b0; core_A = 32'h1; dbg_addr = 32'h4;
        #1;
        n_tests++;
        if (dbg_gnt !== 1'b1 || mem_addr !== 32'h4 || core_rst !== 1'b1) begin
            n_fail++; $display("FAIL mid_boot: got gnt=%b addr=%h core_rst=%b want 1 4 1", dbg_gnt, mem_addr, core_rst);
        end
        exp_q.push_back(exp_mem[4]);
        advance();
        idle_inputs();
        advance();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        idle_inputs();
        test_reset();
        test_boot_load();
        test_boot_go();
        test_contention();
        test_store_vs_dbg();
        test_back_to_back();
        test_starvation();
        test_stop();
        test_midreset();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL drain: got %0d reads outstanding want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
